// File: rtl/nibble_loader.sv
// Serial-to-parallel nibble loader: captures 4 MSB-first bits (plus optional even
// parity) and pulses a one-cycle load into a downstream 4-bit hold/load register.
`timescale 1ns/1ps

module nibble_loader #(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       SerIn,
    input  logic       SerValid,
    output logic [3:0] I,
    output logic       Hold,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] shift_q, shift_nxt;
    logic [1:0] count_q, count_nxt;
    logic       err_q, err_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            shift_q <= 4'b0000;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            count_q <= count_nxt;
            err_q   <= err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        count_nxt = count_q;
        err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    shift_nxt = 4'b0000;
                    count_nxt = 2'd0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (SerValid) begin
                    shift_nxt = {shift_q[2:0], SerIn};
                    count_nxt = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        state_nxt = PARITY_EN ? PARITY : LOAD;
                    end
                end
            end
            PARITY: begin
                if (SerValid) begin
                    if (SerIn == ^shift_q) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The shift register only changes in SHIFT or on Start, so I stays put
    // from LOAD until the next frame begins.
    assign I    = shift_q;
    assign Hold = (state != LOAD);
    assign Busy = (state != IDLE);
    assign Done = (state == LOAD);
    assign Err  = err_q;

endmodule
